vga_timing: RTL and testbench

Single-clock 640x480@60 Hz VGA timing generator that sits directly upstream of the pixel feeder. It produces registered sync, display-active and line/frame boundary strobes, plus a row-prefetch strobe with a source-row index for the 64x48, x10-upscaled framebuffer. All downstream stages take their horizontal and vertical timing from this block.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing.sv | 168 ++++++++++++++++
 tb/tb_vga_timing.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and types for the VGA pipeline.
package vga_pkg;

   // Horizontal timing in pixel clocks
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   // Vertical timing in lines
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Framebuffer geometry: 48 source rows, each shown on 10 output lines
   localparam int SCALE    = 10;
   localparam int SRC_ROWS = 48;

   // Datapath widths
   localparam int CNT_W    = 10;
   localparam int ROW_W    = 6;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [ROW_W-1:0] row_t;

   // Line/frame decodes that are registered together
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic disp_active;
      logic line_end;
      logic frame_end;
   } vga_dec_t;

   // Inclusive window test on a counter value
   function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
      return (x >= lo) && (x <= hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping counter 0..MAX with enable; exposes its next value so the
// parent can register decodes aligned with the count itself.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int WIDTH = CNT_W,
   parameter int MAX   = H_TOTAL - 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;
   logic             w_at_max;

   assign w_at_max = (r_count == LP_MAX);

   // Next count: hold when disabled, wrap to zero after MAX
   always_comb begin
      w_next = r_count;
      if (i_en) begin
         w_next = w_at_max ? '0 : r_count + 1'b1;
      end
   end

   // Reset parks the counter on its last value so the first free edge lands on 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= LP_MAX;
      end else begin
         r_count <= w_next;
      end
   end

   assign o_count = r_count;
   assign o_next  = w_next;
   assign o_wrap  = i_en & w_at_max;

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 Hz VGA timing generator with source-row prefetch strobes for
// the x10-upscaled 64x48 framebuffer. Every output is registered from the
// decode of the counters' next value, so it is coherent with h_count/v_count.
module vga_timing #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int SCALE    = vga_pkg::SCALE,
   parameter int SRC_ROWS = vga_pkg::SRC_ROWS
) (
   input  logic       clk_25,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       disp_active,
   output logic       line_end,
   output logic       frame_end,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       row_prefetch,
   output logic [5:0] src_row
);

   import vga_pkg::*;

   localparam int LP_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int LP_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int SUB_W      = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam cnt_t LP_H_ACT  = cnt_t'(H_ACTIVE);
   localparam cnt_t LP_H_LAST = cnt_t'(LP_H_TOTAL - 1);
   localparam cnt_t LP_HS_LO  = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t LP_HS_HI  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam cnt_t LP_V_ACT  = cnt_t'(V_ACTIVE);
   localparam cnt_t LP_V_LAST = cnt_t'(LP_V_TOTAL - 1);
   localparam cnt_t LP_VS_LO  = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t LP_VS_HI  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [SUB_W-1:0] LP_SUB_LAST = SUB_W'(SCALE - 1);
   localparam row_t             LP_ROW_LAST = row_t'(SRC_ROWS - 1);

   // Geometry must tile the active area exactly and fit the row index
   if (V_ACTIVE != SCALE * SRC_ROWS) begin : g_bad_geometry
      $error("vga_timing: V_ACTIVE (%0d) must equal SCALE*SRC_ROWS (%0d)",
             V_ACTIVE, SCALE * SRC_ROWS);
   end
   if (SRC_ROWS > (1 << ROW_W)) begin : g_bad_rows
      $error("vga_timing: SRC_ROWS (%0d) does not fit src_row", SRC_ROWS);
   end

   cnt_t             w_h_count;
   cnt_t             w_h_next;
   logic             w_h_wrap;
   cnt_t             w_v_count;
   cnt_t             w_v_next;
   logic             w_v_wrap;

   vga_dec_t         w_dec;
   vga_dec_t         r_dec;

   logic [SUB_W-1:0] r_sub;
   row_t             r_row;
   logic             w_pf_row;
   logic             w_pf_wrap;
   row_t             w_pf_src;
   logic             r_row_prefetch;
   row_t             r_src_row;

   vga_axis_counter #(
      .WIDTH (CNT_W),
      .MAX   (LP_H_TOTAL - 1)
   ) u_h_cnt (
      .i_clk   (clk_25),
      .i_rst   (rst),
      .i_en    (1'b1),
      .o_count (w_h_count),
      .o_next  (w_h_next),
      .o_wrap  (w_h_wrap)
   );

   vga_axis_counter #(
      .WIDTH (CNT_W),
      .MAX   (LP_V_TOTAL - 1)
   ) u_v_cnt (
      .i_clk   (clk_25),
      .i_rst   (rst),
      .i_en    (w_h_wrap),
      .o_count (w_v_count),
      .o_next  (w_v_next),
      .o_wrap  (w_v_wrap)
   );

   // Decode the position the counters are about to present
   always_comb begin
      w_dec             = '0;
      w_dec.hsync       = in_window(w_h_next, LP_HS_LO, LP_HS_HI) ? SYNC_POL : ~SYNC_POL;
      w_dec.vsync       = in_window(w_v_next, LP_VS_LO, LP_VS_HI) ? SYNC_POL : ~SYNC_POL;
      w_dec.disp_active = (w_h_next < LP_H_ACT) && (w_v_next < LP_V_ACT);
      w_dec.line_end    = (w_h_next == LP_H_LAST);
      w_dec.frame_end   = (w_h_next == LP_H_LAST) && (w_v_next == LP_V_LAST);
   end

   // Register sync/active/boundary decodes; reset leaves syncs deasserted
   always_ff @(posedge clk_25) begin
      if (rst) begin
         r_dec             <= '0;
         r_dec.hsync       <= ~SYNC_POL;
         r_dec.vsync       <= ~SYNC_POL;
      end else begin
         r_dec             <= w_dec;
      end
   end

   // Sub-row/row tracking: r_sub/r_row describe the line currently on v_count,
   // stepping on each line wrap inside the active area and clearing at frame wrap
   always_ff @(posedge clk_25) begin
      if (rst || w_v_wrap) begin
         r_sub <= '0;
         r_row <= '0;
      end else if (w_h_wrap && (w_v_count < LP_V_ACT)) begin
         if (r_sub == LP_SUB_LAST) begin
            r_sub <= '0;
            r_row <= (r_row == LP_ROW_LAST) ? '0 : r_row + 1'b1;
         end else begin
            r_sub <= r_sub + 1'b1;
         end
      end
   end

   // Prefetch decode at the first blanking clock; the line does not change
   // on that edge, so r_sub/r_row still describe the upcoming position
   always_comb begin
      w_pf_row  = (w_h_next == LP_H_ACT) && (w_v_next < LP_V_ACT) &&
                  (r_sub == LP_SUB_LAST) && (r_row < LP_ROW_LAST);
      w_pf_wrap = (w_h_next == LP_H_ACT) && (w_v_next == LP_V_LAST);
      w_pf_src  = w_pf_row ? r_row + 1'b1 : '0;
   end

   // Register the strobe; src_row is only reloaded when a strobe fires
   always_ff @(posedge clk_25) begin
      if (rst) begin
         r_row_prefetch <= 1'b0;
         r_src_row      <= '0;
      end else begin
         r_row_prefetch <= w_pf_row | w_pf_wrap;
         if (w_pf_row | w_pf_wrap) begin
            r_src_row   <= w_pf_src;
         end
      end
   end

   assign h_count      = w_h_count;
   assign v_count      = w_v_count;
   assign hsync        = r_dec.hsync;
   assign vsync        = r_dec.vsync;
   assign disp_active  = r_dec.disp_active;
   assign line_end     = r_dec.line_end;
   assign frame_end    = r_dec.frame_end;
   assign row_prefetch = r_row_prefetch;
   assign src_row      = r_src_row;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a full-size instance for line-level timing
// and prefetch placement, and a reduced-height/width instance so whole
// frames fit in a short run.
module tb_vga_timing;

   logic clk_25 = 1'b0;
   logic rst    = 1'b1;

   always #20 clk_25 = ~clk_25;

   logic       d_hs, d_vs, d_de, d_le, d_fe, d_pf;
   logic [9:0] d_h, d_v;
   logic [5:0] d_src;
   logic       s_hs, s_vs, s_de, s_le, s_fe, s_pf;
   logic [9:0] s_h, s_v;
   logic [5:0] s_src;

   vga_timing u_dut (
      .clk_25       (clk_25),
      .rst          (rst),
      .hsync        (d_hs),
      .vsync        (d_vs),
      .disp_active  (d_de),
      .line_end     (d_le),
      .frame_end    (d_fe),
      .h_count      (d_h),
      .v_count      (d_v),
      .row_prefetch (d_pf),
      .src_row      (d_src)
   );

   // 96 clocks per line (hsync 72..87), 36 lines (vsync 32..33), 3 source rows
   vga_timing #(
      .H_ACTIVE (64), .H_FP (8), .H_SYNC (16), .H_BP (8),
      .V_ACTIVE (30), .V_FP (2), .V_SYNC (2),  .V_BP (2),
      .SYNC_POL (1'b0), .SCALE (10), .SRC_ROWS (3)
   ) u_small (
      .clk_25       (clk_25),
      .rst          (rst),
      .hsync        (s_hs),
      .vsync        (s_vs),
      .disp_active  (s_de),
      .line_end     (s_le),
      .frame_end    (s_fe),
      .h_count      (s_h),
      .v_count      (s_v),
      .row_prefetch (s_pf),
      .src_row      (s_src)
   );

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs, vs, de, le, fe, pf;
      logic [5:0] src;
   } obs_t;

   // Hand-derived geometry: index 0 = full size, 1 = small
   int HA[2]   = '{640, 64};
   int HSLO[2] = '{656, 72};
   int HSHI[2] = '{751, 87};
   int HT[2]   = '{800, 96};
   int VA[2]   = '{480, 30};
   int VSLO[2] = '{490, 32};
   int VSHI[2] = '{491, 33};
   int VT[2]   = '{525, 36};

   int         eh[2];
   int         ev[2];
   logic [5:0] esrc[2];
   int         bad[2][9];
   string      fname[9] = '{"h", "v", "hsync", "vsync", "disp", "line_end", "frame_end", "prefetch", "src_row"};
   string      dname[2] = '{"full", "small"};

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Stats gathered during the first run after reset
   bit collect = 1'b0;
   int s_de_n = 0, s_vs_low = 0, s_hs_low = 0, s_pf_h_bad = 0;
   int s_pf_v[$], s_pf_src[$], s_fe_cyc[$], d_le_cyc[$], d_pf_v[$], d_pf_src[$];
   int d_hs_low0 = 0, d_hs_first = -1, d_hs_last = -1, de_outside = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance the reference position for one instance and score its outputs
   task automatic step_model(input int k, input obs_t o);
      obs_t e;
      e = '0;
      if (rst) begin
         eh[k]   = HT[k] - 1;
         ev[k]   = VT[k] - 1;
         esrc[k] = '0;
         e.h     = 10'(eh[k]);
         e.v     = 10'(ev[k]);
         e.hs    = 1'b1;
         e.vs    = 1'b1;
      end else begin
         if (eh[k] == HT[k] - 1) begin
            eh[k] = 0;
            ev[k] = (ev[k] == VT[k] - 1) ? 0 : ev[k] + 1;
         end else begin
            eh[k] = eh[k] + 1;
         end
         e.h  = 10'(eh[k]);
         e.v  = 10'(ev[k]);
         e.hs = !(eh[k] >= HSLO[k] && eh[k] <= HSHI[k]);
         e.vs = !(ev[k] >= VSLO[k] && ev[k] <= VSHI[k]);
         e.de = (eh[k] < HA[k]) && (ev[k] < VA[k]);
         e.le = (eh[k] == HT[k] - 1);
         e.fe = e.le && (ev[k] == VT[k] - 1);
         e.pf = (eh[k] == HA[k]) &&
                (((ev[k] < VA[k]) && (ev[k] % 10 == 9) && (ev[k] != VA[k] - 1)) || (ev[k] == VT[k] - 1));
         if (e.pf) esrc[k] = (ev[k] == VT[k] - 1) ? 6'd0 : 6'((ev[k] + 1) / 10);
         e.src = esrc[k];
      end
      if (o.h   !== e.h)   bad[k][0]++;
      if (o.v   !== e.v)   bad[k][1]++;
      if (o.hs  !== e.hs)  bad[k][2]++;
      if (o.vs  !== e.vs)  bad[k][3]++;
      if (o.de  !== e.de)  bad[k][4]++;
      if (o.le  !== e.le)  bad[k][5]++;
      if (o.fe  !== e.fe)  bad[k][6]++;
      if (o.pf  !== e.pf)  bad[k][7]++;
      if (o.src !== e.src) bad[k][8]++;
   endtask

   // One sample point, #1 after the rising edge; c = cycles since release
   task automatic sample_cycle(input int c);
      obs_t od, os;
      od = '{h: d_h, v: d_v, hs: d_hs, vs: d_vs, de: d_de, le: d_le, fe: d_fe, pf: d_pf, src: d_src};
      os = '{h: s_h, v: s_v, hs: s_hs, vs: s_vs, de: s_de, le: s_le, fe: s_fe, pf: s_pf, src: s_src};
      step_model(0, od);
      step_model(1, os);
      if (d_de && (d_h >= 640 || d_v >= 480)) de_outside++;
      if (s_de && (s_h >= 64 || s_v >= 30))   de_outside++;
      if (collect) begin
         if (c <= 3456) begin
            if (s_de)  s_de_n++;
            if (!s_vs) s_vs_low++;
            if (!s_hs) s_hs_low++;
            if (s_pf) begin
               s_pf_v.push_back(int'(s_v));
               s_pf_src.push_back(int'(s_src));
               if (s_h != 10'd64) s_pf_h_bad++;
            end
         end
         if (s_fe) s_fe_cyc.push_back(c);
         if (d_le) d_le_cyc.push_back(c);
         if (d_pf) begin
            d_pf_v.push_back(int'(d_v));
            d_pf_src.push_back(int'(d_src));
         end
         if (c <= 800 && !d_hs) begin
            d_hs_low0++;
            if (d_hs_first < 0) d_hs_first = int'(d_h);
            d_hs_last = int'(d_h);
         end
      end
   endtask

   initial begin
      int gap_bad;
      int pf_c, pf_v, pf_src;
      for (int k = 0; k < 2; k++)
         for (int f = 0; f < 9; f++) bad[k][f] = 0;

      // Reset held for three edges
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk_25); #1;
         sample_cycle(0);
      end
      check("rst_h", d_h, 799);
      check("rst_v", d_v, 524);
      check("rst_disp", d_de, 0);
      check("rst_hsync", d_hs, 1);
      check("rst_vsync", d_vs, 1);
      check("rst_small_h", s_h, 95);

      // Free run; reset re-asserted at full-size position (300,21)
      rst     = 1'b0;
      collect = 1'b1;
      for (int c = 1; c <= 17101; c++) begin
         @(posedge clk_25); #1;
         sample_cycle(c);
         if (c == 1) begin
            check("first_h", d_h, 0);
            check("first_v", d_v, 0);
            check("first_disp", d_de, 1);
            check("first_small_v", s_v, 0);
         end
      end
      collect = 1'b0;
      check("pre_rst_h", d_h, 300);
      check("pre_rst_v", d_v, 21);

      rst = 1'b1;
      @(posedge clk_25); #1;
      sample_cycle(0);
      check("midrst_h", d_h, 799);
      check("midrst_v", d_v, 524);
      check("midrst_disp", d_de, 0);
      check("midrst_prefetch", d_pf, 0);
      check("midrst_src", d_src, 0);
      check("midrst_small_v", s_v, 35);
      repeat (2) begin
         @(posedge clk_25); #1;
         sample_cycle(0);
      end
      check("rst_hold_h", d_h, 799);

      // Restart: first strobe must come from row counter 0 again
      rst    = 1'b0;
      pf_c   = -1;
      pf_v   = -1;
      pf_src = -1;
      for (int c = 1; c <= 8000; c++) begin
         @(posedge clk_25); #1;
         sample_cycle(c);
         if (c == 1) begin
            check("restart_h", d_h, 0);
            check("restart_v", d_v, 0);
            check("restart_disp", d_de, 1);
         end
         if (d_pf && pf_c < 0) begin
            pf_c   = c;
            pf_v   = int'(d_v);
            pf_src = int'(d_src);
         end
      end
      check("restart_pf_cycle", pf_c, 7841);
      check("restart_pf_v", pf_v, 9);
      check("restart_pf_src", pf_src, 1);

      // Full-size line-level results
      check("full_hs_low_line0", d_hs_low0, 96);
      check("full_hs_first", d_hs_first, 656);
      check("full_hs_last", d_hs_last, 751);
      check("full_le_count", d_le_cyc.size(), 21);
      check("full_le_first", (d_le_cyc.size() > 0) ? d_le_cyc[0] : -1, 800);
      gap_bad = 0;
      for (int i = 1; i < d_le_cyc.size(); i++)
         if (d_le_cyc[i] - d_le_cyc[i-1] != 800) gap_bad++;
      check("full_le_gap_bad", gap_bad, 0);
      check("full_pf_count", d_pf_v.size(), 2);
      check("full_pf0_v",   (d_pf_v.size() > 0)   ? d_pf_v[0]   : -1, 9);
      check("full_pf0_src", (d_pf_src.size() > 0) ? d_pf_src[0] : -1, 1);
      check("full_pf1_v",   (d_pf_v.size() > 1)   ? d_pf_v[1]   : -1, 19);
      check("full_pf1_src", (d_pf_src.size() > 1) ? d_pf_src[1] : -1, 2);

      // Small instance whole-frame results
      check("small_disp_per_frame", s_de_n, 1920);
      check("small_vsync_low", s_vs_low, 192);
      check("small_hsync_low", s_hs_low, 576);
      check("small_pf_count", s_pf_v.size(), 3);
      check("small_pf0_v",   (s_pf_v.size() > 0)   ? s_pf_v[0]   : -1, 9);
      check("small_pf0_src", (s_pf_src.size() > 0) ? s_pf_src[0] : -1, 1);
      check("small_pf1_v",   (s_pf_v.size() > 1)   ? s_pf_v[1]   : -1, 19);
      check("small_pf1_src", (s_pf_src.size() > 1) ? s_pf_src[1] : -1, 2);
      check("small_pf2_v",   (s_pf_v.size() > 2)   ? s_pf_v[2]   : -1, 35);
      check("small_pf2_src", (s_pf_src.size() > 2) ? s_pf_src[2] : -1, 0);
      check("small_pf_h_bad", s_pf_h_bad, 0);
      check("small_fe_count", s_fe_cyc.size(), 4);
      check("small_fe_first", (s_fe_cyc.size() > 0) ? s_fe_cyc[0] : -1, 3456);
      gap_bad = 0;
      for (int i = 1; i < s_fe_cyc.size(); i++)
         if (s_fe_cyc[i] - s_fe_cyc[i-1] != 3456) gap_bad++;
      check("small_fe_gap_bad", gap_bad, 0);
      check("disp_outside_window", de_outside, 0);

      // Cycle-by-cycle reference comparison totals
      for (int k = 0; k < 2; k++)
         for (int f = 0; f < 9; f++)
            check($sformatf("model_%s_%s_bad", dname[k], fname[f]), bad[k][f], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
